square_arbiter: RTL and testbench
=================================

# square_arbiter

Round-robin arbiter and sequencer that shares a single instance of the combinational 4-bit squarer among NREQ requesters. Each requester offers a 4-bit operand through a valid/ready handshake. The block grants one requester per cycle, feeds its operand to the squarer, and registers the 8-bit square together with the requester index into a one-entry output stage. That stage drains through its own valid/ready handshake and sits between the operand sources and any downstream consumer of squares.

## Interface
- NREQ, 4: number of requesters, 2..8
- ID_W, 2: width of rsp_id, equal to clog2(NREQ); the instantiating level sets it consistently
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  bit i set: requester i offers an operand
- req_data  in  4*NREQ  operand of requester i on bits [4i+3:4i]
- req_ready  out  NREQ  one-hot or zero; bit i set: operand i accepted this cycle (combinational)
- rsp_valid  out  1  output stage holds a result
- rsp_data  out  8  square of the accepted operand
- rsp_id  out  ID_W  index of the requester that produced rsp_data
- rsp_ready  in  1  consumer takes the result this cycle

## Operation
- can_accept = !rsp_valid || rsp_ready. It is true when the output stage is empty or being drained this cycle.
- Grant selection: scan requesters starting at pointer ptr, wrapping modulo NREQ. The first i with req_valid[i] wins.
- req_ready[i] = can_accept && (i == winner) && req_valid[i]. At most one bit is set. All bits are 0 when no request is pending or when can_accept is low.
- On a transfer (req_valid[i] && req_ready[i]):
  - rsp_data <= square(req_data[i])
  - rsp_id <= i
  - rsp_valid <= 1
  - ptr <= (i+1) mod NREQ
- Drain without a new transfer (rsp_valid && rsp_ready and no grant): rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Drain and transfer in the same cycle: the new result replaces the old one and rsp_valid stays 1. This gives full throughput of one square per cycle.
- Stall (rsp_valid && !rsp_ready): rsp_valid, rsp_data and rsp_id hold, all req_ready bits are 0, and ptr holds.
- Two-state FSM on rsp_valid:
  - EMPTY -> FULL on a transfer
  - FULL -> EMPTY on a drain with no transfer
  - FULL -> FULL on a stall, or on a drain with a transfer
- Requester rule: once req_valid[i] is raised, it and req_data[i] stay stable until req_ready[i]. The block does not check this rule.
- Arithmetic: the result is exact. Range is 0..225 and no bit is truncated.

## Timing
- Reset values: rsp_valid=0, rsp_data=8'h00, rsp_id=0, ptr=0, req_ready=0. After reset, requester 0 has the highest priority.
- Reset wins over any simultaneous handshake. An in-flight result is discarded without a response.
- Latency: operand accepted in cycle N, so rsp_valid=1 with the result in cycle N+1.
- req_ready depends combinationally on req_valid, ptr, rsp_valid and rsp_ready. rsp_* outputs are registered.
- Pointer wrap: after a grant to NREQ-1, ptr returns to 0.
- Fairness: a continuously valid requester is granted within NREQ accepting cycles.

## Configuration
- SQ_ARB_FIXED_PRIO_EN defined:
  - ptr is removed; scanning always starts at index 0, so the lowest index wins
  - no fairness guarantee
- SQ_ARB_FIXED_PRIO_EN undefined: round-robin as described above.

## Structure
- Shared package: the SQ_OPERAND_W=4 and SQ_RESULT_W=8 constants, and the FSM state encoding (EMPTY=0, FULL=1).
- Sub-module: one instance of the existing `square` squarer on the muxed operand. The arbiter itself contains only the mux, the priority scan, ptr and the output register.

## Test plan
- Single request: after reset, req_valid=4'b0001 with req_data[3:0]=3 -> req_ready=4'b0001. Next cycle rsp_valid=1, rsp_data=9, rsp_id=0.
- Full contention: all valid, operands 15, 2, 5, 7, rsp_ready=1 -> results 225/id0, 4/id1, 25/id2, 49/id3 on four consecutive cycles.
- Backpressure: hold rsp_ready=0 while the 225 result is pending -> rsp_data stays 225, req_ready=0 throughout, ptr unchanged. Release -> next grant resumes.
- Wrap: last grant to id3, then req_valid=4'b1001 -> grant id0. Then with req_valid=4'b1000 -> grant id3.
- Reset mid-operation: rsp_valid=1, rsp_data=49, rst=1 for one cycle -> rsp_valid=0, rsp_data=0, rsp_id=0. Next grant favours id0.
- SQ_ARB_FIXED_PRIO_EN build: req_valid=4'b0110 held with operands 4 and 6 -> id1 is granted every cycle with rsp_data=16, and id2 is never granted.

Source files
------------

// File: rtl/square_arbiter_pkg.sv
// Shared constants and result-stage state encoding for square_arbiter.
package square_arbiter_pkg;
    localparam int SQ_OPERAND_W = 4;
    localparam int SQ_RESULT_W  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sq_state_t;
endpackage

// File: rtl/square_arbiter_square.sv
// Combinational exact squarer: 4-bit operand in, full 8-bit square out.
module square
    import square_arbiter_pkg::*;
(
    input  logic [SQ_OPERAND_W-1:0] a,
    output logic [SQ_RESULT_W-1:0]  y
);
    logic [SQ_RESULT_W-1:0] a_ext;

    assign a_ext = SQ_RESULT_W'(a);
    assign y     = a_ext * a_ext;
endmodule

// File: rtl/square_arbiter.sv
// Round-robin arbiter sharing one squarer among NREQ requesters, one-entry output stage.
// Build option SQ_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins, no pointer.
module square_arbiter
    import square_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [SQ_OPERAND_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         rsp_valid,
    output logic [SQ_RESULT_W-1:0]       rsp_data,
    output logic [ID_W-1:0]              rsp_id,
    input  logic                         rsp_ready
);
    sq_state_t               state_reg;
    logic                    can_accept;
    logic                    found;
    logic                    transfer;
    logic [ID_W-1:0]         winner;
    logic [SQ_OPERAND_W-1:0] sel_op;
    logic [SQ_RESULT_W-1:0]  square_y;
    logic [SQ_OPERAND_W-1:0] operands [NREQ];
    int                      scan_start;
    int                      scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign operands[gi]  = req_data[SQ_OPERAND_W*gi +: SQ_OPERAND_W];
            assign req_ready[gi] = transfer && (winner == ID_W'(gi));
        end
    endgenerate

`ifdef SQ_ARB_FIXED_PRIO_EN
    assign scan_start = 0;
`else
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] ptr_next;

    assign scan_start = int'(ptr_reg);
    assign ptr_next   = (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (transfer) begin
            ptr_reg <= ptr_next;
        end
    end
`endif

    // Scan from the start index, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = scan_start + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = ID_W'(scan_idx);
            end
        end
    end

    assign rsp_valid  = (state_reg == FULL);
    assign can_accept = !rsp_valid || rsp_ready;
    assign transfer   = can_accept && found;
    assign sel_op     = operands[winner];

    square u_square (
        .a (sel_op),
        .y (square_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            case (state_reg)
                EMPTY: if (transfer) state_reg <= FULL;
                FULL:  if (rsp_ready && !transfer) state_reg <= EMPTY;
                default: state_reg <= EMPTY;
            endcase
            if (transfer) begin
                rsp_data <= square_y;
                rsp_id   <= winner;
            end
        end
    end
endmodule

// File: tb/tb_square_arbiter.sv
// Directed-vector bench for square_arbiter in its default round-robin build.
module tb_square_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    square_arbiter #(.NREQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
        check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        check({tag, ".data"},  32'(rsp_data),  32'(d));
        check({tag, ".id"},    32'(rsp_id),    32'(id));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        do_reset();
        #1;
        check_rsp("reset", 1'b0, 8'd0, 2'd0);
        check("reset.ready", 32'(req_ready), 32'h0);

        // Single request
        req_valid = 4'b0001;
        req_data  = 16'h0003;
        #1;
        check("single.ready", 32'(req_ready), 32'b0001);
        tick();
        check_rsp("single", 1'b1, 8'd9, 2'd0);
        req_valid = '0;
        tick();
        check("single.drain", 32'(rsp_valid), 32'd0);

        // Full contention after reset: id0 first, then rotating
        do_reset();
        req_data  = {4'd7, 4'd5, 4'd2, 4'd15};
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("cont%0d.ready", k), 32'(req_ready), 32'(1 << k));
            tick();
            case (k)
                0: check_rsp("cont0", 1'b1, 8'd225, 2'd0);
                1: check_rsp("cont1", 1'b1, 8'd4,   2'd1);
                2: check_rsp("cont2", 1'b1, 8'd25,  2'd2);
                default: check_rsp("cont3", 1'b1, 8'd49, 2'd3);
            endcase
            req_valid[k] = 1'b0;
        end

        // Backpressure with all requesters valid; pointer is back at 0
        req_valid = 4'b1111;
        #1;
        check("bp.first", 32'(req_ready), 32'b0001);
        tick();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d.ready", k), 32'(req_ready), 32'h0);
            check_rsp($sformatf("bp%0d", k), 1'b1, 8'd225, 2'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.resume", 32'(req_ready), 32'b0010);
        tick();
        check_rsp("bp.r1", 1'b1, 8'd4, 2'd1);
        tick();
        check_rsp("bp.r2", 1'b1, 8'd25, 2'd2);
        tick();
        check_rsp("bp.r3", 1'b1, 8'd49, 2'd3);

        // Wrap: pointer back at 0 after id3
        req_valid = 4'b1001;
        #1;
        check("wrap.ready0", 32'(req_ready), 32'b0001);
        tick();
        check_rsp("wrap0", 1'b1, 8'd225, 2'd0);
        req_valid = 4'b1000;
        #1;
        check("wrap.ready3", 32'(req_ready), 32'b1000);
        tick();
        check_rsp("wrap3", 1'b1, 8'd49, 2'd3);

        // Rotation skips past the last winner
        req_valid = 4'b0110;
        #1;
        check("rot.ready1", 32'(req_ready), 32'b0010);
        tick();
        #1;
        check("rot.ready2", 32'(req_ready), 32'b0100);
        tick();
        check_rsp("rot2", 1'b1, 8'd25, 2'd2);

        // Reset mid-operation with a pending 49 result
        req_valid = 4'b1000;
        tick();
        check_rsp("pre_rst", 1'b1, 8'd49, 2'd3);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        check_rsp("mid_rst", 1'b0, 8'd0, 2'd0);
        rsp_ready = 1'b1;
        #1;
        check("post_rst.ready", 32'(req_ready), 32'b0001);
        tick();
        check_rsp("post_rst", 1'b1, 8'd225, 2'd0);

        // Drain with no new transfer: data and id hold
        req_valid = '0;
        tick();
        check_rsp("drain", 1'b0, 8'd225, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
